// File: rtl/pll_reset_ctrl.sv
// PLL lock sequencer: pulses PLL reset, qualifies lock, gates system reset, retries on timeout.
module pll_reset_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clki,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic             fail,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] loss_count
);

  localparam int unsigned T_MAX_A = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int unsigned T_MAX   = (LOCK_TIMEOUT > T_MAX_A) ? LOCK_TIMEOUT : T_MAX_A;
  localparam int unsigned TW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int unsigned RW      = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [RW-1:0]    retries_q, retries_d;
  logic [CNT_W-1:0] loss_d;
  logic             lock_meta, lock_s;
  logic             pll_rst_d, sys_rst_n_d, ready_d, fail_d;
  logic             counting;

  assign state = 3'(state_q);

  // Two-flop synchronizer for the asynchronous PLL lock output
  always_ff @(posedge clki) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  // State, counters and registered output decodes
  always_ff @(posedge clki) begin
    if (!rst_n) begin
      state_q    <= ST_RESET_PLL;
      timer_q    <= '0;
      retries_q  <= '0;
      loss_count <= '0;
      pll_rst    <= 1'b1;
      sys_rst_n  <= 1'b0;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retries_q  <= retries_d;
      loss_count <= loss_d;
      pll_rst    <= pll_rst_d;
      sys_rst_n  <= sys_rst_n_d;
      ready      <= ready_d;
      fail       <= fail_d;
    end
  end

  // Next-state, counter updates and output decode of the next state
  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    loss_d    = loss_count;

    unique case (state_q)
      ST_RESET_PLL: begin
        if (timer_q == TW'(RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
          retries_d = retries_q + RW'(1);
          if (retries_q == RW'(MAX_RETRIES - 1)) state_d = ST_FAIL;
          else                                   state_d = ST_RESET_PLL;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (timer_q == TW'(STABLE_CYCLES - 1)) begin
          state_d   = ST_RUN;
          retries_d = '0;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_RESET_PLL;
          if (loss_count != {CNT_W{1'b1}}) loss_d = loss_count + CNT_W'(1);
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_RESET_PLL;
      end
    endcase

    // Restart overrides any transition above; loss counting in RUN is kept
    if (restart) begin
      state_d   = ST_RESET_PLL;
      retries_d = '0;
    end

    // Timer runs only in timed states and clears on every state entry
    counting = (state_q == ST_RESET_PLL) || (state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE);
    if (restart || (state_d != state_q) || !counting) timer_d = '0;
    else                                              timer_d = timer_q + TW'(1);

    pll_rst_d   = (state_d == ST_RESET_PLL);
    sys_rst_n_d = (state_d == ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

endmodule

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

Lock-sequencing and reset controller for the ECP5 EHXPLLL clock generator feeding the Ethernet datapath. Runs on the free-running board reference clock, pulses the PLL's RST input, and waits for a stable `locked`. Releases the system reset only after lock has been continuously held. On lock loss or lock timeout it restarts the PLL, counts the events, and declares failure after a bounded number of retries.

## Interface
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL restart (≥1).
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before a retry (≥2).
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release (≥1).
- `MAX_RETRIES`, 4: consecutive lock timeouts tolerated before FAIL (≥1).
- `CNT_W`, 8: width of `loss_count`.

Ports:
- `clki`  in  1: reference clock (board oscillator, also the PLL's CLKI). Single clock domain.
- `rst_n`  in  1: synchronous, active-low reset.
- `restart`  in  1: single-cycle request to restart the PLL sequence.
- `pll_locked`  in  1: PLL LOCK output. Asynchronous to `clki`.
- `pll_rst`  out  1: drives PLL RST. Active high.
- `sys_rst_n`  out  1: active-low reset for downstream logic.
- `ready`  out  1: PLL locked and stable.
- `fail`  out  1: retry budget exhausted.
- `state`  out  3: current FSM state, for debug.
- `loss_count`  out  CNT_W: number of lock losses seen in RUN. Saturating.

## Operation
- `pll_locked` passes through a 2-flop synchronizer; the result is `lock_s`. All decisions use `lock_s`.
- One timer, width clog2 of the largest cycle parameter. It is cleared on every state entry.
- A retry counter counts lock timeouts.
- FSM states and encoding:
  - RESET_PLL (0): `pll_rst`=1. After exactly RST_CYCLES cycles, go to WAIT_LOCK.
  - WAIT_LOCK (1): if `lock_s`=1, go to STABLE. If the timer reaches LOCK_TIMEOUT-1 with `lock_s`=0, increment retries. If retries then equals MAX_RETRIES, go to FAIL; otherwise go to RESET_PLL.
  - STABLE (2): if `lock_s`=0, return to WAIT_LOCK; no retry is counted. After STABLE_CYCLES consecutive cycles with `lock_s`=1, go to RUN and clear retries.
  - RUN (3): `sys_rst_n`=1, `ready`=1. If `lock_s`=0, saturating-increment `loss_count` and go to RESET_PLL.
  - FAIL (4): `fail`=1, `pll_rst`=0, `sys_rst_n`=0. Stays here until `restart` or `rst_n`.
- `restart`, in any state:
  - Go to RESET_PLL next cycle and clear retries.
  - It has priority over timeout and stable-completion transitions; a concurrent timeout does not count a retry.
  - In RUN, a simultaneous lock loss still increments `loss_count`. Only one transition to RESET_PLL occurs.
- `loss_count` holds at all-ones and never wraps. It is cleared only by `rst_n`.
- `sys_rst_n` is 0 in every state except RUN. Downstream logic synchronizes its deassertion into the `clko` domain.

## Timing
- All outputs are registered decodes of the registered state and counters. They change on the same edge as `state`.
- Reset values, asserted while `rst_n`=0:
  - `state`=RESET_PLL, `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fail`=0.
  - `loss_count`=0, retries=0, timer=0, synchronizer flops=0.
- Reset asserted mid-operation: the next edge forces the reset values regardless of state.
- After `rst_n` rises, `pll_rst` stays 1 for exactly RST_CYCLES edges, then 0.
- `pll_locked` rising lands in `lock_s` 2 cycles later. STABLE is entered the following cycle.
- RUN is entered STABLE_CYCLES cycles after STABLE entry, provided `lock_s` stays high. `ready` and `sys_rst_n` rise on that edge.
- `pll_locked` falling in RUN: `lock_s` falls 2 cycles later. On the next edge `ready`=0, `sys_rst_n`=0, `pll_rst`=1 and `loss_count` increments. Total latency is 3 cycles.
- Lock timeout: WAIT_LOCK lasts exactly LOCK_TIMEOUT cycles.

## Test plan
Parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2, CNT_W=2.
- Clean bring-up: release `rst_n`, raise `pll_locked` at cycle 10.
  - `pll_rst` is high for cycles 0–3.
  - `ready` and `sys_rst_n` rise at cycle 21.
  - `loss_count`=0.
- Glitchy lock: `pll_locked` high for 3 cycles, low for 1, then steady.
  - STABLE aborts back to WAIT_LOCK, no retry is counted.
  - `ready` rises 11 cycles after the final rise.
- Timeout to failure: `pll_locked` held at 0.
  - Two RESET_PLL pulses of 4 cycles each.
  - `fail`=1 and `state`=4 after the second 32-cycle wait.
  - `restart` then returns to RESET_PLL with `fail`=0.
- Lock loss and saturation: in RUN, drop `pll_locked` four times, relocking each time.
  - `loss_count` goes 1, 2, 3, 3.
  - `ready` falls 3 cycles after each drop.
- Simultaneous events:
  - `restart` together with a lock-drop in RUN: a single RESET_PLL entry and `loss_count` +1.
  - `restart` on the timeout cycle: retries stay at 0.
- Reset mid-STABLE: assert `rst_n`=0 for one cycle.
  - All outputs take their reset values on the next edge.
  - `loss_count`=0.
